dlx_hazard_ctrl: RTL and testbench
==================================

# dlx_hazard_ctrl

Pipeline hazard controller for the MIPS-Lite/DLX five-stage pipeline. Tracks the instruction words of the EX, MEM and WB stages in its own registers. Detects load-use hazards on the instruction in ID and sequences one-cycle stalls and bubbles. It also drives every operand bypass select in EX, including the load-to-store SMDR select, and honours data-memory wait states and branch squashes.

## Interface
- No parameters; field positions, opcodes and select encodings come from the shared DLX definitions.
- `clk` input 1: pipeline clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `IRid` input 32: instruction word currently in ID.
- `mem_ready` input 1: data memory done; low freezes the whole pipeline.
- `branch_taken` input 1: branch resolved taken in EX; squashes the instruction in ID.
- `stall` output 1: hold PC and IF/ID register this cycle.
- `freeze` output 1: hold all pipeline registers (equals `!mem_ready`).
- `ALUAsel` output 2: EX operand A source: 00 regfile, 01 MEM-stage result, 10 WB-stage result.
- `ALUBsel` output 2: EX operand B source, same encoding; only valid for R-type EX instructions.
- `SMDRsel` output 1: `select_load_bypass` or `select_ALU_path`.
- `IRex`, `IRmem`, `IRwb` output 32 each: registered stage instruction words.

## Operation
- Fields: op [31:26], rs [25:21], rt [20:16], rd [15:11]. NOP = 32'h0.
- dest(I):
  - rd for R-type (op 0).
  - rt for LW and I-type ALU ops.
  - r0 (none) for SW, branches and jumps.
- Load-use hazard: IRex is LW with rt != r0, and the rt of that LW equals either of:
  - IRid.rs, when IRid reads rs; or
  - IRid.rt, when IRid is R-type.
- SW in ID whose data register (rt) equals the rt of the LW in EX:
  - Resolved by the SMDR bypass when LOAD_STORE_BYPASS_EN is defined.
  - Otherwise it is a hazard.
- `stall` = hazard & !branch_taken & mem_ready.
- Per-edge update, when `freeze` = 0:
  - IRwb <= IRmem.
  - IRmem <= IRex.
  - IRex <= NOP if (`stall` | `branch_taken`), else IRid.
- When `freeze` = 1, all three registers hold.
- Forwarding for operand A:
  - Select 01 when dest(IRmem) != r0, IRmem is not LW, and dest(IRmem) == IRex.rs.
  - Otherwise select 10 when dest(IRwb) != r0 and dest(IRwb) == IRex.rs.
  - Otherwise select 00.
- Operand B uses the same rule with IRex.rt, applied only when IRex is R-type; otherwise 00.
- SMDRsel = load bypass iff IRmem is LW, IRex is SW, IRmem.rt == IRex.rt, and IRex.rt != r0. Compiled only with the macro; without it, always ALU path.
- A LW in MEM never forwards through ALUAsel/ALUBsel; the interlock guarantees that case cannot reach EX.

## Timing
- Reset (async assert): IRex, IRmem and IRwb = NOP. Outputs therefore read `stall` = 0, selects 00, `SMDRsel` = ALU path. `freeze` follows `mem_ready`.
- All outputs except the IR registers are combinational from registered IRs plus `IRid`, `mem_ready` and `branch_taken`; no added latency.
- A load-use stall lasts exactly one cycle, except that it extends while frozen.
- Freeze priority: freeze beats stall and flush. Upstream holds `branch_taken` until `mem_ready` is high, and it is acted on only on an unfrozen edge.
- Stall and flush in the same cycle: flush wins. `stall` = 0 and a NOP is inserted.
- Reset mid-stall: pipeline returns to NOPs, no residual stall.

## Configuration
- `LOAD_STORE_BYPASS_EN` defined:
  - LW then SW with the same rt issues back to back.
  - SMDRsel selects the load bypass in that cycle.
- Not defined:
  - The same pair produces a one-cycle stall.
  - SMDRsel is constant `select_ALU_path`.

## Structure
- Shared definitions (`dlx_defs.v`): field macros, `LW`/`SW`/R-type opcodes, NOP, `r0`, and the `select_*` encodings.
- One sub-module, `hazard_fwd_sel`: compares one source register against IRmem and IRwb and produces a 2-bit select. Instantiated twice, once for A and once for B.
- Dest/uses-field decoding is a small function inside the top.

## Test plan
- ADD r3,r1,r2 then SUB r4,r3,r5 → with SUB in EX, ALUAsel = 01; with one independent instruction between them, ALUAsel = 10.
- LW r3,0(r1) then ADD r4,r3,r2 → `stall` = 1 for one cycle, IRex = NOP next edge, then ALUAsel = 10.
- LW r3 then SW r3,4(r1):
  - With macro: no stall, SMDRsel = load bypass in the SW EX cycle.
  - Without macro: one stall, SMDRsel stays ALU path.
- LW r0 then ADD r4,r0,r0 → no stall, all selects 00.
- `mem_ready` = 0 for 3 cycles during a load-use stall → IRex/IRmem/IRwb unchanged throughout, then the stall completes once.
- `branch_taken` = 1 while a load-use hazard is present → `stall` = 0, IRex = NOP; `rst_n` pulsed low mid-sequence → all IRs = 0 immediately.

Source files
------------

// File: rtl/dlx_hazard_ctrl_pkg.sv
// Shared DLX definitions for the hazard controller: instruction fields, opcodes,
// the NOP word, the r0 register and the bypass select encodings.
package dlx_hazard_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQZ  = 6'h04;
    localparam logic [5:0] OP_BNEZ  = 6'h05;
    localparam logic [5:0] OP_JR    = 6'h12;
    localparam logic [5:0] OP_JALR  = 6'h13;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // I-type ALU opcodes occupy one contiguous block (ADDI .. LHI)
    localparam logic [5:0] OP_IALU_LO = 6'h08;
    localparam logic [5:0] OP_IALU_HI = 6'h0F;

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [4:0]  R0  = 5'd0;

    typedef enum logic [1:0] {
        SEL_REGFILE = 2'b00,
        SEL_MEM     = 2'b01,
        SEL_WB      = 2'b10
    } fwd_sel_e;

    localparam logic SELECT_ALU_PATH    = 1'b0;
    localparam logic SELECT_LOAD_BYPASS = 1'b1;

    function automatic logic [5:0] op_of(input logic [31:0] ir);
        return ir[31:26];
    endfunction

    function automatic logic [4:0] rs_of(input logic [31:0] ir);
        return ir[25:21];
    endfunction

    function automatic logic [4:0] rt_of(input logic [31:0] ir);
        return ir[20:16];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] ir);
        return ir[15:11];
    endfunction

    function automatic logic is_ialu(input logic [5:0] op);
        return (op >= OP_IALU_LO) && (op <= OP_IALU_HI);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Bypass select for one EX source register: MEM-stage result has priority over
// WB-stage result; a load sitting in MEM is never a forwarding source.
module hazard_fwd_sel (
    input  logic       enable,
    input  logic [4:0] src,
    input  logic [4:0] mem_dest,
    input  logic       mem_is_lw,
    input  logic [4:0] wb_dest,
    output logic [1:0] sel
);
    import dlx_hazard_ctrl_pkg::*;

    always_comb begin
        sel = SEL_REGFILE;
        if (enable) begin
            if ((mem_dest != R0) && !mem_is_lw && (mem_dest == src)) begin
                sel = SEL_MEM;
            end else if ((wb_dest != R0) && (wb_dest == src)) begin
                sel = SEL_WB;
            end
        end
    end

endmodule

// File: rtl/dlx_hazard_ctrl.sv
// DLX five-stage hazard controller: load-use interlock, EX operand bypass selects,
// SMDR load-to-store bypass (only when LOAD_STORE_BYPASS_EN is defined), freeze and squash.
module dlx_hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] IRid,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        stall,
    output logic        freeze,
    output logic [1:0]  ALUAsel,
    output logic [1:0]  ALUBsel,
    output logic        SMDRsel,
    output logic [31:0] IRex,
    output logic [31:0] IRmem,
    output logic [31:0] IRwb
);
    import dlx_hazard_ctrl_pkg::*;

    // Register written by an instruction; r0 means "writes nothing"
    function automatic logic [4:0] dest_of(input logic [31:0] ir);
        logic [5:0] op;
        op = op_of(ir);
        if (op == OP_RTYPE) begin
            return rd_of(ir);
        end else if ((op == OP_LW) || is_ialu(op)) begin
            return rt_of(ir);
        end
        return R0;
    endfunction

    function automatic logic reads_rs(input logic [31:0] ir);
        logic [5:0] op;
        op = op_of(ir);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || is_ialu(op) ||
               (op == OP_BEQZ) || (op == OP_BNEZ) || (op == OP_JR) || (op == OP_JALR);
    endfunction

    logic [4:0] load_rt;
    logic       ex_is_load;
    logic       haz_rs;
    logic       haz_rt;
    logic       haz_sw;
    logic       hazard;
    logic       flush_or_stall;
    logic       ex_is_rtype;

    assign load_rt    = rt_of(IRex);
    assign ex_is_load = (op_of(IRex) == OP_LW) && (load_rt != R0);

    assign haz_rs = reads_rs(IRid) && (rs_of(IRid) == load_rt);
    assign haz_rt = (op_of(IRid) == OP_RTYPE) && (rt_of(IRid) == load_rt);

`ifdef LOAD_STORE_BYPASS_EN
    // The store data is picked off the load bypass in EX, so no interlock needed
    assign haz_sw = 1'b0;
`else
    assign haz_sw = (op_of(IRid) == OP_SW) && (rt_of(IRid) == load_rt);
`endif

    assign hazard         = ex_is_load && (haz_rs || haz_rt || haz_sw);
    assign stall          = hazard && !branch_taken && mem_ready;
    assign freeze         = !mem_ready;
    assign flush_or_stall = stall || branch_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            IRex  <= NOP;
            IRmem <= NOP;
            IRwb  <= NOP;
        end else if (!freeze) begin
            IRwb  <= IRmem;
            IRmem <= IRex;
            IRex  <= flush_or_stall ? NOP : IRid;
        end
    end

    logic [4:0] mem_dest;
    logic [4:0] wb_dest;
    logic       mem_is_lw;

    assign mem_dest    = dest_of(IRmem);
    assign wb_dest     = dest_of(IRwb);
    assign mem_is_lw   = (op_of(IRmem) == OP_LW);
    assign ex_is_rtype = (op_of(IRex) == OP_RTYPE);

    hazard_fwd_sel u_fwd_a (
        .enable    (1'b1),
        .src       (rs_of(IRex)),
        .mem_dest  (mem_dest),
        .mem_is_lw (mem_is_lw),
        .wb_dest   (wb_dest),
        .sel       (ALUAsel)
    );

    // Only R-type instructions take operand B from a register
    hazard_fwd_sel u_fwd_b (
        .enable    (ex_is_rtype),
        .src       (rt_of(IRex)),
        .mem_dest  (mem_dest),
        .mem_is_lw (mem_is_lw),
        .wb_dest   (wb_dest),
        .sel       (ALUBsel)
    );

`ifdef LOAD_STORE_BYPASS_EN
    assign SMDRsel = (mem_is_lw && (op_of(IRex) == OP_SW) &&
                      (rt_of(IRmem) == rt_of(IRex)) && (rt_of(IRex) != R0))
                     ? SELECT_LOAD_BYPASS : SELECT_ALU_PATH;
`else
    assign SMDRsel = SELECT_ALU_PATH;
`endif

endmodule

// File: tb/tb_dlx_hazard_ctrl.sv
// Directed scoreboard bench for dlx_hazard_ctrl; expectations follow LOAD_STORE_BYPASS_EN.
module tb_dlx_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] IRid;
    logic        mem_ready;
    logic        branch_taken;
    logic        stall;
    logic        freeze;
    logic [1:0]  ALUAsel;
    logic [1:0]  ALUBsel;
    logic        SMDRsel;
    logic [31:0] IRex;
    logic [31:0] IRmem;
    logic [31:0] IRwb;

    dlx_hazard_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .IRid         (IRid),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .stall        (stall),
        .freeze       (freeze),
        .ALUAsel      (ALUAsel),
        .ALUBsel      (ALUBsel),
        .SMDRsel      (SMDRsel),
        .IRex         (IRex),
        .IRmem        (IRmem),
        .IRwb         (IRwb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        stall;
        logic        freeze;
        logic [1:0]  a;
        logic [1:0]  b;
        logic        smdr;
        logic [31:0] ex;
        logic [31:0] mem;
        logic [31:0] wb;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_ex  = 32'h0;
    logic [31:0] m_mem = 32'h0;
    logic [31:0] m_wb  = 32'h0;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'h00, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag, input logic [31:0] irid, input logic mr,
                        input logic bt, input logic es, input logic [1:0] ea,
                        input logic [1:0] eb, input logic esm);
        exp_t e;
        exp_t got;
        IRid         = irid;
        mem_ready    = mr;
        branch_taken = bt;
        e.tag = tag; e.stall = es; e.freeze = !mr; e.a = ea; e.b = eb; e.smdr = esm;
        e.ex = m_ex; e.mem = m_mem; e.wb = m_wb;
        exp_q.push_back(e);
        @(negedge clk);
        got = exp_q.pop_front();
        chk({got.tag, ".stall"},  {31'h0, stall},   {31'h0, got.stall});
        chk({got.tag, ".freeze"}, {31'h0, freeze},  {31'h0, got.freeze});
        chk({got.tag, ".ALUAsel"}, {30'h0, ALUAsel}, {30'h0, got.a});
        chk({got.tag, ".ALUBsel"}, {30'h0, ALUBsel}, {30'h0, got.b});
        chk({got.tag, ".SMDRsel"}, {31'h0, SMDRsel}, {31'h0, got.smdr});
        chk({got.tag, ".IRex"},  IRex,  got.ex);
        chk({got.tag, ".IRmem"}, IRmem, got.mem);
        chk({got.tag, ".IRwb"},  IRwb,  got.wb);
        $display("step %-12s IRid=%h mr=%0b bt=%0b stall=%0b A=%0d B=%0d smdr=%0b IRex=%h",
                 tag, irid, mr, bt, stall, ALUAsel, ALUBsel, SMDRsel, IRex);
        @(posedge clk);
        if (mr) begin
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (es || bt) ? 32'h0 : irid;
        end
        #1;
    endtask

    logic [31:0] add1, add1b, sub1, addi1, bdep, lw1, add2, sw1, lw0, add0, nop;

    initial begin
        nop   = 32'h0;
        add1  = rtype(5'd1, 5'd2, 5'd3, 6'h20);       // add r3,r1,r2
        add1b = rtype(5'd5, 5'd5, 5'd3, 6'h20);       // add r3,r5,r5
        sub1  = rtype(5'd3, 5'd5, 5'd4, 6'h22);       // sub r4,r3,r5
        addi1 = itype(6'h08, 5'd6, 5'd7, 16'd1);      // addi r7,r6,1
        bdep  = rtype(5'd2, 5'd4, 5'd10, 6'h20);      // add r10,r2,r4
        lw1   = itype(6'h23, 5'd1, 5'd3, 16'd0);      // lw r3,0(r1)
        add2  = rtype(5'd3, 5'd2, 5'd4, 6'h20);       // add r4,r3,r2
        sw1   = itype(6'h2B, 5'd1, 5'd3, 16'd4);      // sw r3,4(r1)
        lw0   = itype(6'h23, 5'd1, 5'd0, 16'd0);      // lw r0,0(r1)
        add0  = rtype(5'd0, 5'd0, 5'd4, 6'h20);       // add r4,r0,r0

        rst_n = 1'b0; IRid = add2; mem_ready = 1'b0; branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.freeze_lo_ready", {31'h0, freeze}, 32'h1);
        mem_ready = 1'b1;
        #1;
        chk("rst.freeze_hi_ready", {31'h0, freeze}, 32'h0);
        chk("rst.IRex",  IRex,  32'h0);
        chk("rst.IRmem", IRmem, 32'h0);
        chk("rst.IRwb",  IRwb,  32'h0);
        chk("rst.stall", {31'h0, stall}, 32'h0);
        chk("rst.selA",  {30'h0, ALUAsel}, 32'h0);
        chk("rst.SMDR",  {31'h0, SMDRsel}, 32'h0);
        $display("reset checks done IRex=%h IRmem=%h IRwb=%h", IRex, IRmem, IRwb);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Back-to-back dependence: forward from MEM
        step("add1",      add1,  1, 0, 0, 2'b00, 2'b00, 0);
        step("sub1",      sub1,  1, 0, 0, 2'b00, 2'b00, 0);
        step("addi_a01",  addi1, 1, 0, 0, 2'b01, 2'b00, 0);
        step("nop_itype", nop,   1, 0, 0, 2'b00, 2'b00, 0);
        // One independent instruction between: forward from WB
        step("add1_b",    add1,  1, 0, 0, 2'b00, 2'b00, 0);
        step("addi_b",    addi1, 1, 0, 0, 2'b00, 2'b00, 0);
        step("sub1_b",    sub1,  1, 0, 0, 2'b00, 2'b00, 0);
        step("nop_a10",   nop,   1, 0, 0, 2'b10, 2'b00, 0);
        // Operand B from MEM
        step("sub1_c",    sub1,  1, 0, 0, 2'b00, 2'b00, 0);
        step("bdep",      bdep,  1, 0, 0, 2'b00, 2'b00, 0);
        step("nop_b01",   nop,   1, 0, 0, 2'b00, 2'b01, 0);
        // MEM beats WB when both match
        step("add1_d",    add1,  1, 0, 0, 2'b00, 2'b00, 0);
        step("add1b",     add1b, 1, 0, 0, 2'b00, 2'b00, 0);
        step("sub1_d",    sub1,  1, 0, 0, 2'b00, 2'b00, 0);
        step("nop_prio",  nop,   1, 0, 0, 2'b01, 2'b00, 0);
        // Load-use: one stall, then WB forward
        step("lw1",       lw1,   1, 0, 0, 2'b00, 2'b00, 0);
        step("lu_stall",  add2,  1, 0, 1, 2'b00, 2'b00, 0);
        step("lu_retry",  add2,  1, 0, 0, 2'b00, 2'b00, 0);
        step("lu_a10",    nop,   1, 0, 0, 2'b10, 2'b00, 0);
        // Load then store of the loaded register
        step("ls_lw",     lw1,   1, 0, 0, 2'b00, 2'b00, 0);
`ifdef LOAD_STORE_BYPASS_EN
        step("ls_sw",     sw1,   1, 0, 0, 2'b00, 2'b00, 0);
        step("ls_bypass", nop,   1, 0, 0, 2'b00, 2'b00, 1);
`else
        step("ls_stall",  sw1,   1, 0, 1, 2'b00, 2'b00, 0);
        step("ls_sw",     sw1,   1, 0, 0, 2'b00, 2'b00, 0);
        step("ls_sw_ex",  nop,   1, 0, 0, 2'b00, 2'b00, 0);
`endif
        step("drain1",    nop,   1, 0, 0, 2'b00, 2'b00, 0);
        step("drain2",    nop,   1, 0, 0, 2'b00, 2'b00, 0);
        // Load into r0 creates no dependence
        step("lw0",       lw0,   1, 0, 0, 2'b00, 2'b00, 0);
        step("add0",      add0,  1, 0, 0, 2'b00, 2'b00, 0);
        step("r0_ex",     nop,   1, 0, 0, 2'b00, 2'b00, 0);
        step("r0_drain",  nop,   1, 0, 0, 2'b00, 2'b00, 0);
        step("r0_drain2", nop,   1, 0, 0, 2'b00, 2'b00, 0);
        // Freeze for three cycles during a load-use hazard
        step("fz_lw",     lw1,   1, 0, 0, 2'b00, 2'b00, 0);
        for (int i = 0; i < 3; i++) begin
            step("fz_hold",   add2, 0, 0, 0, 2'b00, 2'b00, 0);
        end
        step("fz_stall",  add2,  1, 0, 1, 2'b00, 2'b00, 0);
        step("fz_issue",  add2,  1, 0, 0, 2'b00, 2'b00, 0);
        step("fz_a10",    nop,   1, 0, 0, 2'b10, 2'b00, 0);
        // Branch squash wins over the interlock
        step("br_lw",     lw1,   1, 0, 0, 2'b00, 2'b00, 0);
        step("br_flush",  add2,  1, 1, 0, 2'b00, 2'b00, 0);
        step("br_after",  nop,   1, 0, 0, 2'b00, 2'b00, 0);
        // Reset pulse in the middle of a stall
        step("rs_lw",     lw1,   1, 0, 0, 2'b00, 2'b00, 0);
        IRid = add2;
        @(negedge clk);
        chk("rs.pre_stall", {31'h0, stall}, 32'h1);
        chk("rs.pre_IRex", IRex, lw1);
        #1 rst_n = 1'b0;
        #1;
        chk("rs.IRex",  IRex,  32'h0);
        chk("rs.IRmem", IRmem, 32'h0);
        chk("rs.IRwb",  IRwb,  32'h0);
        chk("rs.stall", {31'h0, stall}, 32'h0);
        $display("reset pulse mid-stall IRex=%h IRmem=%h IRwb=%h stall=%0b", IRex, IRmem, IRwb, stall);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_ex = 32'h0; m_mem = 32'h0; m_wb = 32'h0;
        step("rs_after",  add2,  1, 0, 0, 2'b00, 2'b00, 0);
        step("rs_after2", nop,   1, 0, 0, 2'b00, 2'b00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
